// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the PC into a combinational instruction memory,
// buffers the returned words with their PCs, and hands them to decode via valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [31:0]   pc_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [31:0]   instr_buf [DEPTH];
    logic [31:0]   pc_buf    [DEPTH];

    logic deq;
    logic fetch;

    assign imem_addr = pc_reg;
    assign out_valid = (count_reg != '0);
    assign deq       = out_valid & out_ready;
    // A full buffer may still fetch when the head leaves in the same cycle.
    assign fetch     = !redirect_valid & ((count_reg < DEPTH_C) | deq);

    assign out_instr = out_valid ? instr_buf[rd_ptr_reg] : 32'h0;
    assign out_pc    = out_valid ? pc_buf[rd_ptr_reg]    : 32'h0;

    // Entry storage carries no reset; count_reg alone decides what is valid.
    always_ff @(posedge clk) begin
        if (fetch) begin
            instr_buf[wr_ptr_reg] <= imem_instr;
            pc_buf[wr_ptr_reg]    <= pc_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect_valid) begin
            // Any concurrent handshake is honoured by simply discarding everything.
            pc_reg     <= redirect_pc & ~32'h3;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fetch) begin
                pc_reg     <= pc_reg + 32'd4;
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({fetch, deq})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan scenarios followed by random
// ready/redirect traffic, checked by a queue-based reference model and a negedge monitor.
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h4011_0233;
            32'h40:  return 32'h0000_0000;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched-but-undelivered {pc, instr} pairs and the next PC.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = RESET_PC;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pc = RESET_PC;
        end else begin
            int  held;
            bit  took;
            held = exp_q.size();
            took = (held > 0) && out_ready;
            if (took)
                $display("deq pc=%h instr=%h", exp_q[0][63:32], exp_q[0][31:0]);
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (took) void'(exp_q.pop_front());
                if (held < DEPTH || took) begin
                    exp_q.push_back({m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: compares the DUT's presented output against the model's head every cycle.
    always @(negedge clk) begin
        chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        chk("imem_addr", imem_addr, m_pc);
        if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0][63:32]);
            chk("out_instr", out_instr, exp_q[0][31:0]);
        end else begin
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_instr", out_instr, 32'h0);
        end
    end

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rp);
        out_ready      = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        // Straight-line fetch at full throughput.
        do_reset();
        cyc(1, 0, 0);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h0050_0093);
        repeat (4) cyc(1, 0, 0);

        // Stall: buffer fills, PC holds, head stable, then drain in order.
        do_reset();
        repeat (5) cyc(0, 0, 0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_head_pc", out_pc, 32'h0);
        chk("stall_head_instr", out_instr, 32'h0050_0093);
        cyc(1, 0, 0);
        chk("drain0_pc", out_pc, 32'h4);
        cyc(1, 0, 0);
        chk("drain1_pc", out_pc, 32'h8);

        // Redirect while buffer holds 0x8 and 0xC.
        do_reset();
        repeat (2) cyc(0, 0, 0);
        repeat (2) cyc(1, 0, 0);
        chk("pre_redir_pc", out_pc, 32'h8);
        cyc(0, 1, 32'h24);
        chk("redir_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h24);
        cyc(1, 0, 0);
        chk("redir_pc", out_pc, 32'h24);

        // Redirect with misaligned target concurrent with a handshake.
        cyc(1, 1, 32'h27);
        chk("mis_addr", imem_addr, 32'h24);
        cyc(1, 0, 0);
        chk("mis_pc", out_pc, 32'h24);

        // Wrap at the top of the address space.
        cyc(1, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        cyc(1, 0, 0);
        chk("wrap_pc1", out_pc, 32'h0);

        // Zero instruction words are buffered like any other.
        cyc(1, 1, 32'h40);
        cyc(0, 0, 0);
        chk("zero_valid", {31'h0, out_valid}, 32'h1);
        chk("zero_pc", out_pc, 32'h40);

        // Reset asserted mid-operation with two entries held.
        repeat (3) cyc(0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_instr", out_instr, 32'h0);
        chk("midrst_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0);
        chk("resume_pc", out_pc, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        rv;
            logic [31:0] rp;
            r  = ($urandom_range(0, 9) < 7);
            rv = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 31) * 4 + $urandom_range(0, 3))
                                             : $urandom();
            cyc(r, rv, rp);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
